// File: rtl/demux1to4_buf.sv
// demux1to4_buf: registered 1-to-4 valid/ready stream demux; DEMUX_COUNT_EN adds per-destination delivery counters
module demux1to4_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            control_signal,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [3:0]            o_valid,
  input  logic [3:0]            i_ready,
  output logic [DATA_WIDTH-1:0] o_data_0,
  output logic [DATA_WIDTH-1:0] o_data_1,
  output logic [DATA_WIDTH-1:0] o_data_2,
  output logic [DATA_WIDTH-1:0] o_data_3
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]           o_count_0,
  output logic [15:0]           o_count_1,
  output logic [15:0]           o_count_2,
  output logic [15:0]           o_count_3
`endif
);
  logic [3:0] valid_q, valid_d, ld, drn;
  logic [DATA_WIDTH-1:0] data_q [4];
  logic [DATA_WIDTH-1:0] data_d [4];
  // a load wins over a drain on the same slot, so a draining slot refills without a bubble
  always_comb begin
    o_ready = !rst && (!valid_q[control_signal] || i_ready[control_signal]);
    ld = (i_valid && o_ready) ? 4'b0001 << control_signal : 4'b0000;
    drn = valid_q & i_ready;
    valid_d = ld | (valid_q & ~drn);
    for (int k = 0; k < 4; k++) data_d[k] = ld[k] ? i_data : data_q[k];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) data_q[k] <= data_d[k];
    end
  end
  assign o_valid  = valid_q;
  assign o_data_0 = data_q[0];
  assign o_data_1 = data_q[1];
  assign o_data_2 = data_q[2];
  assign o_data_3 = data_q[3];
`ifdef DEMUX_COUNT_EN
  logic [15:0] count_q [4];
  logic [15:0] count_d [4];
  always_comb begin
    for (int k = 0; k < 4; k++) count_d[k] = count_q[k] + 16'(drn[k]);
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) count_q[k] <= rst ? 16'd0 : count_d[k];
  end
  assign o_count_0 = count_q[0];
  assign o_count_1 = count_q[1];
  assign o_count_2 = count_q[2];
  assign o_count_3 = count_q[3];
`endif
endmodule

// File: tb/tb_demux1to4_buf.sv
// tb_demux1to4_buf: directed and random checks of demux1to4_buf against a slot-level reference model
module tb_demux1to4_buf;
  logic        clk = 0;
  logic        rst = 1;
  logic [1:0]  control_signal = 0;
  logic        i_valid = 0;
  logic [31:0] i_data = 0;
  logic        o_ready;
  logic [3:0]  o_valid;
  logic [3:0]  i_ready = 0;
  logic [31:0] o_data_0, o_data_1, o_data_2, o_data_3;
  logic [15:0] o_count_0, o_count_1, o_count_2, o_count_3;
  int errors = 0;
  int checks = 0;
  logic        m_full [4];
  logic [31:0] m_word [4];
  logic [15:0] m_cnt  [4];

  always #5 clk = ~clk;

  demux1to4_buf #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .control_signal(control_signal), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_data_0(o_data_0), .o_data_1(o_data_1), .o_data_2(o_data_2), .o_data_3(o_data_3)
`ifdef DEMUX_COUNT_EN
    , .o_count_0(o_count_0), .o_count_1(o_count_1), .o_count_2(o_count_2), .o_count_3(o_count_3)
`endif
  );

`ifndef DEMUX_COUNT_EN
  assign o_count_0 = 0;
  assign o_count_1 = 0;
  assign o_count_2 = 0;
  assign o_count_3 = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] odata(input int k);
    return k == 0 ? o_data_0 : k == 1 ? o_data_1 : k == 2 ? o_data_2 : o_data_3;
  endfunction

  function automatic logic [15:0] ocnt(input int k);
    return k == 0 ? o_count_0 : k == 1 ? o_count_1 : k == 2 ? o_count_2 : o_count_3;
  endfunction

  // one cycle: drive at negedge, compare just after, advance the model at posedge
  task automatic cyc(input logic r, input logic v, input logic [1:0] s, input logic [31:0] d,
                     input logic [3:0] rdy, input bit full_chk = 1);
    logic er, acc;
    logic [3:0] ev;
    rst = r; i_valid = v; control_signal = s; i_data = d; i_ready = rdy;
    #1;
    er = !r && (!m_full[s] || rdy[s]);
    acc = v && er;
    for (int k = 0; k < 4; k++) ev[k] = m_full[k];
    chk("o_ready", {31'd0, o_ready}, {31'd0, er});
    if (full_chk) begin
      chk("o_valid", {28'd0, o_valid}, {28'd0, ev});
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("o_data_%0d", k), odata(k), m_word[k]);
`ifdef DEMUX_COUNT_EN
        chk($sformatf("o_count_%0d", k), {16'd0, ocnt(k)}, {16'd0, m_cnt[k]});
`endif
      end
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (r) begin
        m_full[k] = 0; m_word[k] = 0; m_cnt[k] = 0;
      end else begin
        if (m_full[k] && rdy[k]) begin
          m_cnt[k] = m_cnt[k] + 16'd1;
          m_full[k] = 0;
        end
        if (acc && int'(s) == k) begin
          m_full[k] = 1; m_word[k] = d;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin m_full[k] = 0; m_word[k] = 0; m_cnt[k] = 0; end
    @(negedge clk);
    cyc(1, 1, 2'd1, 32'h1111_1111, 4'b0000);
    cyc(1, 1, 2'd2, 32'h2222_2222, 4'b1111);
    chk("reset_valid", {28'd0, o_valid}, 32'd0);
    chk("reset_data2", o_data_2, 32'd0);
    cyc(0, 0, 2'd0, 32'h0, 4'b0000);
    cyc(0, 0, 2'd3, 32'h0, 4'b0000);
    cyc(0, 1, 2'd2, 32'hA5A5_0001, 4'b0000);
    chk("route_valid", {28'd0, o_valid}, 32'h4);
    chk("route_data2", o_data_2, 32'hA5A5_0001);
    cyc(0, 0, 2'd0, 32'h0, 4'b0100);
    cyc(0, 0, 2'd0, 32'h0, 4'b0000);
    chk("route_drained", {28'd0, o_valid}, 32'h0);
    cyc(0, 1, 2'd1, 32'hB0B0_0001, 4'b0000);
    cyc(0, 1, 2'd1, 32'hB0B0_0002, 4'b0000);
    chk("bp_data1", o_data_1, 32'hB0B0_0001);
    cyc(0, 1, 2'd3, 32'hC0C0_0003, 4'b0000);
    chk("bp_slot3", o_data_3, 32'hC0C0_0003);
    cyc(0, 0, 2'd0, 32'h0, 4'b1010);
    for (int i = 0; i < 8; i++) cyc(0, 1, 2'd0, 32'(i), 4'b0001);
    cyc(0, 0, 2'd0, 32'h0, 4'b0001);
    cyc(0, 0, 2'd0, 32'h0, 4'b0000);
    cyc(0, 1, 2'd0, 32'hD0D0_0000, 4'b0000);
    cyc(0, 1, 2'd3, 32'hD0D0_0003, 4'b0000);
    cyc(1, 0, 2'd0, 32'h0, 4'b0000);
    chk("midrst_valid", {28'd0, o_valid}, 32'h0);
    cyc(0, 1, 2'd0, 32'hE0E0_0000, 4'b0000);
    chk("postrst_data0", o_data_0, 32'hE0E0_0000);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom), $urandom, 4'($urandom));
`ifdef DEMUX_COUNT_EN
    cyc(1, 0, 2'd0, 32'h0, 4'b0000);
    for (int i = 0; i < 65537; i++) cyc(0, 1, 2'd1, 32'(i), 4'b0010, 0);
    cyc(0, 0, 2'd0, 32'h0, 4'b0010);
    cyc(0, 0, 2'd0, 32'h0, 4'b0000);
    chk("wrap_count1", {16'd0, o_count_1}, 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1to4_buf.md
# demux1to4_buf

Registered 1-to-4 stream demultiplexer with a valid/ready handshake on every port. It routes each accepted input word to one of four destinations selected by a 2-bit control, and holds it in that destination's single-entry output register until the destination accepts it. It is the distribution counterpart of the result-select mux: one producer feeds four consumers, such as writeback, CSR, load/store and debug paths.

## Interface
- `DATA_WIDTH`, default 32: width of the data path.
- `clk  input  1`: clock; all state updates on the rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `control_signal  input  2`: destination select, sampled with `i_valid`.
- `i_valid  input  1`: input word valid.
- `i_data  input  DATA_WIDTH`: input word.
- `o_ready  output  1`: input accepted this cycle when `i_valid && o_ready`.
- `o_valid  output  4`: bit k set means `o_data_k` holds a word.
- `o_data_0` … `o_data_3  output  DATA_WIDTH`: per-destination output registers.
- `i_ready  input  4`: bit k means destination k accepts `o_data_k` this cycle.
- `o_count_0` … `o_count_3  output  16`: per-destination delivered-word counters. Present only with `DEMUX_COUNT_EN`.

## Operation
- Each destination k has a slot with two states, EMPTY (`o_valid[k]=0`) and FULL (`o_valid[k]=1`).
- Accept: `acc = i_valid && o_ready`. Let `s = control_signal`.
- Drain of k: `drn_k = o_valid[k] && i_ready[k]`.
- `o_ready = !rst && (!o_valid[s] || i_ready[s])`. It is combinational and depends only on the selected slot, so a full slot never blocks traffic to the other slots.
- On `acc`, `o_data_s <= i_data` and `o_valid[s] <= 1`.
- For each k where `drn_k` holds and no accept targets k, `o_valid[k] <= 0`. `o_data_k` keeps its last value and is don't-care while invalid.
- Simultaneous drain and accept on the same slot k: the new word loads and `o_valid[k]` stays 1. There is no bubble, so a slot sustains 1 word/cycle.
- Drains on other slots proceed in the same cycle as an accept, independently.
- `control_signal` is ignored when `i_valid=0`. Every 2-bit value is a legal destination.
- Word order is preserved per destination. No ordering is implied across destinations.
- Once `o_valid[k]=1`, `o_data_k` must stay stable until `drn_k`. The producer may drop `i_valid` or change `control_signal` before it is accepted; the block must not depend on either holding.

## Timing
- Reset, when `rst=1` at a rising edge: `o_valid=4'b0000`, all `o_data_k=0`, all `o_count_k=0`.
- Any words buffered at reset are discarded. `o_ready=0` for every cycle in which `rst=1`.
- Latency: a word accepted at edge N appears on `o_valid[s]`/`o_data_s` after edge N. There is no combinational path from `i_data` to any `o_data_k`.
- `o_ready` depends combinationally on `rst`, `control_signal`, `o_valid`, `i_ready`. It must not depend on `i_valid`.
- Throughput is 1 word/cycle while the selected destination keeps `i_ready` high.

## Configuration
- `DEMUX_COUNT_EN` defined: `o_count_k` increments by 1 on every `drn_k`. It is 16-bit and wraps from 0xFFFF to 0x0000. Reset clears it.
- `DEMUX_COUNT_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset and idle: hold `rst=1` for 2 cycles with `i_valid=1` -> `o_ready=0`, `o_valid=0000`, all data and counters 0. Release with `i_valid=0` -> `o_valid` stays 0000.
- Basic route: send 0xA5A5_0001 with sel=2 and `i_ready=0000` -> next cycle `o_valid=0100`, `o_data_2=0xA5A5_0001`. Then `i_ready=0100` -> following cycle `o_valid=0000`, and `o_count_2=1` if `DEMUX_COUNT_EN` is defined.
- Backpressure isolation: slot 1 full with `i_ready[1]=0`. Sel=1 -> `o_ready=0` and `o_data_1` is unchanged. Sel=3 in the same state -> `o_ready=1` and the word lands in slot 3.
- Streaming: sel=0 with `i_ready[0]=1` constantly, 8 words 0..7 back-to-back -> `o_ready=1` every cycle, `o_data_0` shows 0..7 on consecutive cycles, no gaps, counter reaches 8.
- Mid-operation reset: slots 0 and 3 full, assert `rst` for 1 cycle -> `o_valid=0000` and counters 0. The next accepted word to sel=0 appears normally.
- Counter wrap (`DEMUX_COUNT_EN`): drive 65,537 drains on slot 1 -> `o_count_1=1`.
